sample_sched: RTL and testbench

SAMPLE_SCHED -- requirements
Module: sample_sched

---
 rtl/sample_sched.sv | 129 ++++++++++++
 tb/tb_sample_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_sched.sv
// sample_sched: three-requester scheduler. It grants one requester at a time
// for up to HOLD_MAX beats. Define SCHED_FIXED_PRIO_EN for fixed a > b > c priority.
module sample_sched #(
  parameter int DW       = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    req,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  output logic [2:0]    grant,
  output logic [2:0]    ack,
  output logic [DW-1:0] d,
  output logic          d_valid,
  input  logic          d_ready,
  output logic          busy
);

  // state   | meaning
  // S_IDLE  | no owner; arbitrate on any req, grant lands next edge
  // S_GRANT | one requester owns d until HOLD_MAX beats or it drops req
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(HOLD_MAX - 1);

  state_t     r_state;
  logic [2:0] r_grant;
  logic [3:0] r_beat_cnt;
  logic       r_busy;

  logic [2:0] w_winner;
  logic       w_gnt_req;
  logic       w_xfer;
  logic       w_release;

`ifdef SCHED_FIXED_PRIO_EN
  always_comb begin
    w_winner = 3'b000;
    if (req[0])      w_winner = 3'b001;
    else if (req[1]) w_winner = 3'b010;
    else if (req[2]) w_winner = 3'b100;
  end
`else
  logic [2:0] r_ptr;

  // Search begins at the pointer bit and wraps a -> b -> c.
  always_comb begin
    w_winner = 3'b000;
    case (r_ptr)
      3'b010: begin
        if (req[1])      w_winner = 3'b010;
        else if (req[2]) w_winner = 3'b100;
        else if (req[0]) w_winner = 3'b001;
      end
      3'b100: begin
        if (req[2])      w_winner = 3'b100;
        else if (req[0]) w_winner = 3'b001;
        else if (req[1]) w_winner = 3'b010;
      end
      default: begin
        if (req[0])      w_winner = 3'b001;
        else if (req[1]) w_winner = 3'b010;
        else if (req[2]) w_winner = 3'b100;
      end
    endcase
  end
`endif

  assign w_gnt_req = (r_state == S_GRANT) && ((req & r_grant) != 3'b000);
  assign w_xfer    = w_gnt_req && d_ready;
  assign w_release = (r_state == S_GRANT) &&
                     (!w_gnt_req || (w_xfer && (r_beat_cnt == LAST_BEAT)));

  always_comb begin
    d = '0;
    if (r_state == S_GRANT) begin
      if (r_grant[0])      d = a;
      else if (r_grant[1]) d = b;
      else if (r_grant[2]) d = c;
    end
    d_valid = w_gnt_req;
    ack     = w_xfer ? r_grant : 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= 3'b000;
      r_beat_cnt <= 4'd0;
      r_busy     <= 1'b0;
`ifndef SCHED_FIXED_PRIO_EN
      r_ptr      <= 3'b001;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req != 3'b000) begin
            r_state    <= S_GRANT;
            r_grant    <= w_winner;
            r_beat_cnt <= 4'd0;
            r_busy     <= 1'b1;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_state    <= S_IDLE;
            r_grant    <= 3'b000;
            r_beat_cnt <= 4'd0;
            r_busy     <= 1'b0;
`ifndef SCHED_FIXED_PRIO_EN
            r_ptr      <= {r_grant[1:0], r_grant[2]};
`endif
          end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 4'd1;
          end
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign busy  = r_busy;

endmodule

// File: tb/tb_sample_sched.sv
// Bench for sample_sched: directed scenarios plus random traffic, all checked
// against an index-based behavioural model of the scheduling rules.
module tb_sample_sched;
  localparam int DW   = 8;
  localparam int HOLD = 4;
  localparam int VW   = 8 + DW;
`ifdef SCHED_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    req = 3'b000;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic [DW-1:0] c = '0;
  logic          d_ready = 1'b0;
  logic [2:0]    grant;
  logic [2:0]    ack;
  logic [DW-1:0] d;
  logic          d_valid;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // model: owner index 0=a,1=b,2=c; pointer as an index
  bit m_active = 1'b0;
  int m_g = 0;
  int m_beats = 0;
  int m_ptr = 0;

  sample_sched #(.DW(DW), .HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c),
    .grant(grant), .ack(ack), .d(d), .d_valid(d_valid),
    .d_ready(d_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pick(int idx);
    return (idx == 0) ? a : ((idx == 1) ? b : c);
  endfunction

  function automatic logic [2:0] onehot(int i);
    logic [2:0] v;
    v = 3'b000;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [2:0] g;
    logic dv;
    logic [2:0] k;
    logic [DW-1:0] dd;
    g  = m_active ? onehot(m_g) : 3'b000;
    dv = m_active && req[m_g];
    k  = (dv && d_ready) ? g : 3'b000;
    dd = m_active ? pick(m_g) : '0;
    return {g, k, m_active, dv, dd};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {grant, ack, busy, d_valid, d};
  endfunction

  task automatic model_release();
    m_active = 1'b0;
    if (!FIXED) m_ptr = (m_g + 1) % 3;
  endtask

  task automatic model_edge();
    bit found;
    int idx;
    if (!m_active) begin
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
        idx = FIXED ? k : (m_ptr + k) % 3;
        if (!found && req[idx]) begin
          found = 1'b1;
          m_g = idx;
        end
      end
      if (found) begin
        m_active = 1'b1;
        m_beats = 0;
      end
    end else if (!req[m_g]) begin
      model_release();
    end else if (d_ready) begin
      m_beats++;
      if (m_beats == HOLD) model_release();
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_ptr = 0;
      m_beats = 0;
      m_g = 0;
    end else begin
      model_edge();
    end
  end

  task automatic drive(input logic [2:0] r, input logic rdy,
                       input logic [DW-1:0] va, input logic [DW-1:0] vb,
                       input logic [DW-1:0] vc);
    @(negedge clk);
    req = r;
    d_ready = rdy;
    a = va;
    b = vb;
    c = vc;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 3'b000;
    d_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(3'b111, 1'b1, DW'($urandom), DW'($urandom), DW'($urandom));
      checks++;
      if (obs_vec() !== {3'b000, 3'b000, 1'b0, 1'b0, {DW{1'b0}}}) begin
        errors++;
        $display("FAIL reset_state cyc%0d got=%h required=%h", i, obs_vec(), {3'b000, 3'b000, 1'b0, 1'b0, {DW{1'b0}}});
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] seq [8];
    int acks [8];
    int gaps [8];
    logic [2:0] exp_seq [4];
    logic [2:0] prev;
    int nseq;
    int idle;
    apply_reset();
    prev = 3'b000;
    nseq = 0;
    idle = 0;
    for (int i = 0; i < 8; i++) begin
      seq[i] = 3'b000;
      acks[i] = 0;
      gaps[i] = 0;
    end
    for (int i = 0; i < 20; i++) begin
      drive(3'b111, 1'b1, DW'($urandom), DW'($urandom), DW'($urandom));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rr_cycle%0d got=%h required=%h", i, obs_vec(), exp_vec());
      end
      if (grant != 3'b000 && prev == 3'b000 && nseq < 8) begin
        seq[nseq] = grant;
        gaps[nseq] = idle;
        nseq++;
      end
      if (ack != 3'b000 && nseq > 0) acks[nseq-1]++;
      if (grant == 3'b000) idle++;
      else idle = 0;
      prev = grant;
    end
    exp_seq[0] = 3'b001;
    exp_seq[1] = FIXED ? 3'b001 : 3'b010;
    exp_seq[2] = FIXED ? 3'b001 : 3'b100;
    exp_seq[3] = 3'b001;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seq[k] !== exp_seq[k]) begin
        errors++;
        $display("FAIL rr_order grant#%0d got=%b required=%b", k, seq[k], exp_seq[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (acks[k] != HOLD) begin
        errors++;
        $display("FAIL rr_acks grant#%0d got=%0d required=%0d", k, acks[k], HOLD);
      end
      checks++;
      if (gaps[k+1] != 1) begin
        errors++;
        $display("FAIL rr_gap before grant#%0d got=%0d required=1", k + 1, gaps[k+1]);
      end
    end
  endtask

  task automatic test_stall();
    logic rdy;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      rdy = (i >= 4);
      drive(3'b010, rdy, DW'($urandom), 8'h5A, DW'($urandom));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stall_cycle%0d got=%h required=%h", i, obs_vec(), exp_vec());
      end
      if (i >= 1 && i <= 4) begin
        checks++;
        if (d !== 8'h5A || d_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold cyc%0d got d=%h dv=%b required d=5a dv=1", i, d, d_valid);
        end
        checks++;
        if (ack !== ((i == 4) ? 3'b010 : 3'b000)) begin
          errors++;
          $display("FAIL stall_ack cyc%0d got=%b required=%b", i, ack, (i == 4) ? 3'b010 : 3'b000);
        end
      end
    end
  endtask

  task automatic test_drop();
    logic [2:0] r;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      r = (i <= 2) ? 3'b001 : ((i == 3) ? 3'b000 : 3'b111);
      drive(r, 1'b1, DW'($urandom), DW'($urandom), DW'($urandom));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL drop_cycle%0d got=%h required=%h", i, obs_vec(), exp_vec());
      end
      if (i == 3) begin
        checks++;
        if (grant !== 3'b001 || ack !== 3'b000 || d_valid !== 1'b0) begin
          errors++;
          $display("FAIL drop_lowreq got g=%b k=%b dv=%b required g=001 k=000 dv=0", grant, ack, d_valid);
        end
      end
      if (i == 4) begin
        checks++;
        if (grant !== 3'b000 || busy !== 1'b0) begin
          errors++;
          $display("FAIL drop_idle got g=%b busy=%b required g=000 busy=0", grant, busy);
        end
      end
      if (i == 5) begin
        checks++;
        if (grant !== (FIXED ? 3'b001 : 3'b010) || busy !== 1'b1) begin
          errors++;
          $display("FAIL drop_next got g=%b busy=%b required g=%b busy=1", grant, busy, FIXED ? 3'b001 : 3'b010);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(3'b100, 1'b1, DW'($urandom), DW'($urandom), DW'($urandom));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rstmid_cycle%0d got=%h required=%h", i, obs_vec(), exp_vec());
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 3'b000 || ack !== 3'b000 || busy !== 1'b0 || d_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got g=%b k=%b busy=%b dv=%b required all zero", grant, ack, busy, d_valid);
    end
    drive(3'b101, 1'b1, DW'($urandom), DW'($urandom), DW'($urandom));
    rst_n = 1'b1;
    drive(3'b101, 1'b1, DW'($urandom), DW'($urandom), DW'($urandom));
    checks++;
    if (grant !== 3'b001) begin
      errors++;
      $display("FAIL rstmid_regrant got=%b required=001", grant);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL rstmid_model got=%h required=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_prio();
    int cnt_c;
    logic [2:0] first;
    apply_reset();
    cnt_c = 0;
    first = 3'b000;
    for (int i = 0; i < 30; i++) begin
      drive(3'b110, 1'b1, DW'($urandom), DW'($urandom), DW'($urandom));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL prio_cycle%0d got=%h required=%h", i, obs_vec(), exp_vec());
      end
      if (grant == 3'b100) cnt_c++;
      if (first == 3'b000) first = grant;
    end
    checks++;
    if (first !== 3'b010) begin
      errors++;
      $display("FAIL prio_first got=%b required=010", first);
    end
    checks++;
    if ((cnt_c == 0) !== FIXED) begin
      errors++;
      $display("FAIL prio_c_grants got=%0d cycles, required none=%0b", cnt_c, FIXED);
    end
  endtask

  task automatic test_random();
    logic [2:0] r;
    apply_reset();
    r = 3'($urandom);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3, 0) == 0) r = 3'($urandom);
      drive(r, 1'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle%0d req=%b rdy=%b got=%h required=%h", i, req, d_ready, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_drop();
    test_reset_mid();
    test_prio();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
